dmem_responder: RTL and testbench

Data-side memory responder that serves the MEM stage's data requests (valid, address, size, byte strobe, store data) and returns a full 32-bit word with a one-cycle data_ok pulse. It contains the backing word-addressed RAM and a configurable-latency response sequencer. It allows one outstanding request. The MEM stage holds its stall until resp_valid; byte/halfword extraction and sign extension stay in the MEM stage.

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the MEM stage.
// Holds the word-addressed backing RAM and sequences one outstanding request
// through a configurable response latency, returning the pre-write word.

typedef enum logic [1:0] {
  MSIZE1 = 2'd0,
  MSIZE2 = 2'd1,
  MSIZE4 = 2'd2
} msize_t;

module dmem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  msize_t      req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  input  logic        req_cancel,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   accept_c;
  logic                   enter_resp_c;

  logic [31:0]            addr_q;
  logic [31:0]            data_q;
  logic [3:0]             strobe_q;
  msize_t                 size_q;

  logic [31:0]            mem [DEPTH];

  logic [31:0]            look_addr_c;
  logic [ADDR_BITS-1:0]   look_idx_c;
  logic                   look_oor_c;
  logic [ADDR_BITS-1:0]   commit_idx_c;
  logic                   commit_oor_c;

  // Size and the byte offset are carried for reporting only.
  logic                   unused_bits;
  assign unused_bits = ^{size_q, addr_q[1:0], look_addr_c[1:0]};

  // Address used for the response read: live request when a LATENCY==1
  // accept jumps straight to RESP, otherwise the latched copy.
  assign look_addr_c  = (state == S_IDLE) ? req_addr : addr_q;
  assign look_idx_c   = look_addr_c[ADDR_BITS+1:2];
  assign look_oor_c   = |look_addr_c[31:ADDR_BITS+2];
  assign commit_idx_c = addr_q[ADDR_BITS+1:2];
  assign commit_oor_c = |addr_q[31:ADDR_BITS+2];

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept, count down, single-cycle response.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept_c     = 1'b0;
    enter_resp_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !req_cancel) begin
          accept_c  = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (req_cancel) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    enter_resp_c = (state_nxt == S_RESP);
  end

  // Request latch and registered handshake/response outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= '0;
      data_q     <= '0;
      strobe_q   <= '0;
      size_q     <= MSIZE1;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q   <= req_addr;
        data_q   <= req_data;
        strobe_q <= req_strobe;
        size_q   <= req_size;
      end
      req_ready  <= (state_nxt == S_IDLE);
      busy       <= (state_nxt != S_IDLE);
      resp_valid <= enter_resp_c;
      if (enter_resp_c) begin
        resp_err  <= look_oor_c;
        resp_data <= look_oor_c ? 32'h0 : mem[look_idx_c];
      end
    end
  end

  // Byte-lane store commit at the closing edge of RESP.
  always_ff @(posedge clk) begin
    if (resetn && (state == S_RESP) && !commit_oor_c) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe_q[i]) begin
          mem[commit_idx_c][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY=2 main
// instance) plus LATENCY=1 and LATENCY=15 instances driven with requests held high.

module tb_dmem_responder;

  localparam int unsigned AB      = 12;
  localparam int unsigned LAT     = 2;
  localparam int unsigned SW_LAT0 = 1;
  localparam int unsigned SW_LAT1 = 15;
  localparam int unsigned NWORDS  = 16;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req_valid;
  logic [31:0] req_addr;
  msize_t      req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        req_cancel;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  dmem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .req_cancel(req_cancel), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  // Latency sweep instances: loads issued back to back with valid held high.
  logic        sw_resetn;
  logic        sw_valid;
  logic        sw_ready [2];
  logic        sw_rv    [2];
  logic        sw_err   [2];
  logic        sw_busy  [2];
  logic [31:0] sw_data  [2];

  for (genvar g = 0; g < 2; g++) begin : g_sw
    dmem_responder #(.ADDR_BITS(AB), .LATENCY(g == 0 ? SW_LAT0 : SW_LAT1)) u_sw (
      .clk(clk), .resetn(sw_resetn), .req_valid(sw_valid), .req_addr(32'h0000_0040),
      .req_size(MSIZE4), .req_strobe(4'b0000), .req_data(32'h0), .req_cancel(1'b0),
      .req_ready(sw_ready[g]), .resp_valid(sw_rv[g]), .resp_data(sw_data[g]),
      .resp_err(sw_err[g]), .busy(sw_busy[g])
    );
  end

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] mdl   [NWORDS];
  bit          known [NWORDS];
  bit          prev_rv;

  int          sw_last  [2];
  int          sw_exp   [2];
  int          sw_nacc  [2];
  int          sw_nresp [2];
  bit          sw_pend  [2];
  bit          sw_prev  [2];
  bit          sw_go;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic int sw_lat(input int k);
    return (k == 0) ? int'(SW_LAT0) : int'(SW_LAT1);
  endfunction

  // Reference memory: byte-lane merge of a store into a word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                        input logic [31:0] d);
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    return w;
  endfunction

  // Issue one request; when tracked, the expected response goes to the scoreboard.
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input bit track);
    int   n;
    exp_t e;
    int   idx;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      fail_now("issue_timeout", "req_ready never returned");
      return;
    end
    req_valid  = 1'b1;
    req_addr   = a;
    req_strobe = s;
    req_data   = d;
    req_size   = msize_t'($urandom_range(0, 2));
    @(posedge clk);
    #1;
    e.acc      = cyc;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_data   = $urandom;
    req_strobe = 4'($urandom);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_ready", 32'(req_ready), 32'd0);
    if (track) begin
      e.err = (a[31:AB+2] != '0);
      idx   = int'(a[AB+1:2]);
      if (e.err) begin
        e.data = 32'h0;
        e.chk  = 1'b1;
      end else if (idx < int'(NWORDS)) begin
        e.data     = mdl[idx];
        e.chk      = known[idx];
        mdl[idx]   = merge(mdl[idx], s, d);
      end else begin
        e.data = 32'h0;
        e.chk  = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy !== 1'b0) fail_now("drain_timeout", "responses still outstanding");
  endtask

  // Main monitor: pop and compare on every response pulse.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      check("resp_back_to_back", 32'(prev_rv), 32'd0);
      if (sb.size() == 0) begin
        fail_now("resp_unexpected", "resp_valid with nothing outstanding");
      end else begin
        mon_e = sb.pop_front();
        check("resp_latency", 32'(cyc), 32'(mon_e.acc + int'(LAT) - 1));
        check("resp_err", 32'(resp_err), 32'(mon_e.err));
        if (mon_e.chk) check("resp_data", resp_data, mon_e.data);
      end
    end
    prev_rv = (resp_valid === 1'b1);
  end

  // Sweep monitor: accept spacing, response timing, one response per accept.
  always @(negedge clk) begin
    if (sw_go) begin
      for (int k = 0; k < 2; k++) begin
        if (sw_rv[k] === 1'b1) begin
          check($sformatf("sw%0d_back_to_back", sw_lat(k)), 32'(sw_prev[k]), 32'd0);
          if (!sw_pend[k]) fail_now($sformatf("sw%0d_unexpected", sw_lat(k)), "resp_valid without accept");
          else check($sformatf("sw%0d_latency", sw_lat(k)), 32'(cyc), 32'(sw_exp[k]));
          sw_pend[k] = 1'b0;
          sw_nresp[k]++;
        end
        sw_prev[k] = (sw_rv[k] === 1'b1);
        if (sw_ready[k] === 1'b1 && sw_valid === 1'b1) begin
          check($sformatf("sw%0d_overlap", sw_lat(k)), 32'(sw_pend[k]), 32'd0);
          if (sw_nacc[k] > 0)
            check($sformatf("sw%0d_spacing", sw_lat(k)), 32'(cyc + 1 - sw_last[k]), 32'(sw_lat(k) + 1));
          sw_last[k] = cyc + 1;
          sw_exp[k]  = cyc + sw_lat(k);
          sw_pend[k] = 1'b1;
          sw_nacc[k]++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = MSIZE4;
    req_strobe = '0;
    req_data   = '0;
    req_cancel = 1'b0;
    sw_resetn  = 1'b0;
    sw_valid   = 1'b0;
    sw_go      = 1'b0;
    prev_rv    = 1'b0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      sw_last[k] = 0; sw_exp[k] = 0; sw_nacc[k] = 0; sw_nresp[k] = 0;
      sw_pend[k] = 1'b0; sw_prev[k] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    sw_resetn = 1'b1;
    sw_valid  = 1'b1;
    sw_go     = 1'b1;

    // Give every tracked word a known value.
    for (int i = 0; i < int'(NWORDS); i++) begin
      issue(32'(i * 4), 4'hF, $urandom, 1'b1);
      known[i] = 1'b1;
    end

    // Full-word store then load.
    issue(32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1);
    issue(32'h10, 4'h0, $urandom, 1'b1);

    // Byte and halfword lane merges.
    issue(32'h10, 4'hF, 32'h1122_3344, 1'b1);
    issue(32'h13, 4'b1000, 32'h7777_7777, 1'b1);
    issue(32'h10, 4'h0, $urandom, 1'b1);
    issue(32'h10, 4'b0011, 32'hAAAA_AAAA, 1'b1);
    issue(32'h10, 4'h0, $urandom, 1'b1);

    // Cancel in WAIT: nothing returned, nothing written.
    issue(32'h20, 4'hF, 32'h5, 1'b0);
    req_cancel = 1'b1;
    @(posedge clk);
    #1;
    req_cancel = 1'b0;
    check("cancel_wait_busy", 32'(busy), 32'd0);
    check("cancel_wait_ready", 32'(req_ready), 32'd1);
    issue(32'h20, 4'h0, $urandom, 1'b1);

    // Cancel during RESP is ignored: store commits.
    issue(32'h20, 4'hF, 32'h5, 1'b1);
    @(posedge clk);
    #1;
    req_cancel = 1'b1;
    @(posedge clk);
    #1;
    req_cancel = 1'b0;
    issue(32'h20, 4'h0, $urandom, 1'b1);

    // Cancel together with valid in IDLE blocks the accept.
    drain();
    @(negedge clk);
    req_valid  = 1'b1;
    req_cancel = 1'b1;
    req_addr   = 32'h24;
    req_strobe = 4'hF;
    req_data   = $urandom;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_cancel = 1'b0;
    check("cancel_accept_busy", 32'(busy), 32'd0);
    check("cancel_accept_ready", 32'(req_ready), 32'd1);
    issue(32'h24, 4'h0, $urandom, 1'b1);

    // Out-of-range store: error, zero data, no write.
    issue(32'h0000_4000, 4'hF, $urandom, 1'b1);
    issue(32'h0, 4'h0, $urandom, 1'b1);

    // Reset during WAIT drops the store.
    drain();
    issue(32'h30, 4'hF, $urandom, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_wait_ready", 32'(req_ready), 32'd1);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_resp_valid", 32'(resp_valid), 32'd0);
    issue(32'h30, 4'h0, $urandom, 1'b1);

    // Randomized traffic over the tracked words, with occasional out-of-range addresses.
    for (int t = 0; t < 60; t++) begin
      a = {18'b0, 12'($urandom_range(0, int'(NWORDS) - 1)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a[$urandom_range(14, 31)] = 1'b1;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      issue(a, s, $urandom, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    // Stop the sweep and let the last responses land.
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    sw_go = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("sw%0d_resp_count", sw_lat(k)), 32'(sw_nresp[k]), 32'(sw_nacc[k]));
      check($sformatf("sw%0d_some_accepts", sw_lat(k)), 32'(sw_nacc[k] > 4), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
